// File: rtl/pe_array_seq_if.sv
// pe_array_seq_if: host stream, pe_array link and result stream of the frame sequencer
interface pe_array_seq_if #(parameter int DATA_WIDTH = 16);
  logic start, reload, s_valid, s_ready, pe_load, pe_din_v, pe_dout_v, m_valid, m_ready, busy, done;
  logic [2*DATA_WIDTH-1:0] s_data, pe_din, pe_dout, m_data;
  logic [1:0] err;
  modport master (
    output start, reload, s_valid, s_data, pe_dout_v, pe_dout, m_ready,
    input  s_ready, pe_load, pe_din_v, pe_din, m_valid, m_data, busy, done, err
  );
  modport slave (
    input  start, reload, s_valid, s_data, pe_dout_v, pe_dout, m_ready,
    output s_ready, pe_load, pe_din_v, pe_din, m_valid, m_data, busy, done, err
  );
endinterface

// File: rtl/pe_array_seq.sv
// pe_array_seq: frame sequencer feeding pe_array and buffering its results in a FWFT FIFO
module pe_array_seq #(
  parameter int DATA_WIDTH    = 16,
  parameter int COEF_LEN      = 8,
  parameter int DATA_LEN      = 24,
  parameter int OUT_LEN       = 8,
  parameter int FIFO_DEPTH    = 32,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input logic clk,
  input logic rst,
  pe_array_seq_if.slave bus
);
  localparam int CW = $clog2((COEF_LEN > DATA_LEN ? COEF_LEN : DATA_LEN) + 1);
  localparam int RW = $clog2(OUT_LEN + 1);
  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = AW + 1;
  localparam logic [CW-1:0] COEF_LAST = CW'(COEF_LEN - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_LEN - 1);
  localparam logic [RW-1:0] RES_MAX   = RW'(OUT_LEN);
  localparam logic [TW-1:0] TMO_LAST  = TW'(DRAIN_TIMEOUT - 1);
  localparam logic [FW-1:0] DEPTH     = FW'(FIFO_DEPTH);
  localparam logic [FW-1:0] NEED      = FW'(OUT_LEN);
  typedef enum logic [2:0] {IDLE, WAIT_SPACE, LOAD, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] in_cnt_q, in_cnt_d;
  logic [RW-1:0] res_cnt_q, res_cnt_d;
  logic [TW-1:0] idle_cnt_q, idle_cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FW-1:0] cnt_q, cnt_d, free;
  logic [1:0] err_q, err_d;
  logic reload_q, reload_d, coef_loaded_q, coef_loaded_d, done_q, done_d;
  logic pe_load_q, pe_load_d, pe_din_v_q, pe_din_v_d;
  logic [2*DATA_WIDTH-1:0] pe_din_q, pe_din_d;
  logic [2*DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic s_rdy, m_vld, acc, pop, res_ok, push;
  assign s_rdy = state_q == LOAD || state_q == RUN;
  assign m_vld = cnt_q != '0;
  always_comb begin
    acc = bus.s_valid & s_rdy;
    pop = m_vld & bus.m_ready;
    free = DEPTH - cnt_q + FW'(pop);
    res_ok = bus.pe_dout_v && (state_q == RUN || state_q == DRAIN) && res_cnt_q != RES_MAX;
    // a full FIFO still takes the word when the host pops in the same cycle
    push = res_ok && (cnt_q != DEPTH || pop);
    state_d = state_q;
    in_cnt_d = in_cnt_q;
    res_cnt_d = res_cnt_q + RW'(res_ok);
    idle_cnt_d = idle_cnt_q;
    reload_d = reload_q;
    coef_loaded_d = coef_loaded_q;
    done_d = 1'b0;
    err_d = err_q | {1'b0, bus.pe_dout_v & ~push};
    pe_din_v_d = acc;
    pe_load_d = acc && state_q == LOAD;
    pe_din_d = acc ? bus.s_data : pe_din_q;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_d = cnt_q + FW'(push) - FW'(pop);
    case (state_q)
      IDLE: if (bus.start) begin
        reload_d = bus.reload | ~coef_loaded_q;
        in_cnt_d = '0;
        res_cnt_d = '0;
        state_d = WAIT_SPACE;
      end
      WAIT_SPACE: state_d = free >= NEED ? (reload_q ? LOAD : RUN) : WAIT_SPACE;
      LOAD: if (acc) begin
        in_cnt_d = in_cnt_q == COEF_LAST ? '0 : in_cnt_q + CW'(1);
        coef_loaded_d = coef_loaded_q | (in_cnt_q == COEF_LAST);
        state_d = in_cnt_q == COEF_LAST ? RUN : LOAD;
      end
      RUN: if (acc) begin
        in_cnt_d = in_cnt_q == DATA_LAST ? '0 : in_cnt_q + CW'(1);
        idle_cnt_d = '0;
        state_d = in_cnt_q == DATA_LAST ? DRAIN : RUN;
      end
      DRAIN: if (res_cnt_q == RES_MAX) begin
        done_d = 1'b1;
        state_d = IDLE;
      end else if (bus.pe_dout_v) begin
        idle_cnt_d = '0;
      end else if (idle_cnt_q == TMO_LAST) begin
        err_d[1] = 1'b1;
        done_d = 1'b1;
        state_d = IDLE;
      end else begin
        idle_cnt_d = idle_cnt_q + TW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      in_cnt_q <= '0;
      res_cnt_q <= '0;
      idle_cnt_q <= '0;
      reload_q <= 1'b0;
      coef_loaded_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= '0;
      pe_din_v_q <= 1'b0;
      pe_load_q <= 1'b0;
      pe_din_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      in_cnt_q <= in_cnt_d;
      res_cnt_q <= res_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      reload_q <= reload_d;
      coef_loaded_q <= coef_loaded_d;
      done_q <= done_d;
      err_q <= err_d;
      pe_din_v_q <= pe_din_v_d;
      pe_load_q <= pe_load_d;
      pe_din_q <= pe_din_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr_q] <= bus.pe_dout;
  assign bus.s_ready = s_rdy;
  assign bus.m_valid = m_vld;
  assign bus.m_data = m_vld ? mem[rd_ptr_q] : '0;
  assign bus.busy = state_q != IDLE;
  assign bus.done = done_q;
  assign bus.err = err_q;
  assign bus.pe_load = pe_load_q;
  assign bus.pe_din_v = pe_din_v_q;
  assign bus.pe_din = pe_din_q;
endmodule

// File: tb/tb_pe_array_seq.sv
// tb_pe_array_seq: vector table, directed corner sequences and random frames against a queue model
module tb_pe_array_seq;
  localparam int COEF = 8, DATA = 24, OUTN = 8;
  typedef struct {
    string nm;
    logic start, reload, s_valid;
    logic [31:0] s_data;
    logic e_s_ready, e_busy, e_din_v, e_load;
    logic [31:0] e_din;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  int checks = 0, errors = 0, done_cnt = 0, d0 = 0;
  bit coef_m = 1'b0;
  logic [31:0] exp_res[$];
  pe_array_seq_if #(.DATA_WIDTH(16)) bus ();
  pe_array_seq dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.done) done_cnt++;
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic start_frame(input logic rl, output bit ld);
    ld = rl | !coef_m;
    d0 = done_cnt;
    bus.start = 1'b1;
    bus.reload = rl;
    tick();
    bus.start = 1'b0;
    bus.reload = 1'b0;
    check("busy_after_start", 32'(bus.busy), 1);
  endtask
  task automatic send_word(input logic [31:0] w, input int gap, input logic ld);
    int n = 0;
    bus.s_valid = 1'b0;
    repeat (gap) tick();
    bus.s_valid = 1'b1;
    bus.s_data = w;
    while (!bus.s_ready && n < 300) begin
      tick();
      n++;
    end
    check("s_ready_at_accept", 32'(bus.s_ready), 1);
    tick();
    bus.s_valid = 1'b0;
    check("pe_din_v_lat1", 32'(bus.pe_din_v), 1);
    check("pe_din", bus.pe_din, w);
    check("pe_load", 32'(bus.pe_load), 32'(ld));
  endtask
  task automatic send_frame_words(input bit ld, input int maxgap);
    if (ld) begin
      for (int i = 0; i < COEF; i++) send_word($urandom, $urandom_range(0, maxgap), 1'b1);
      coef_m = 1'b1;
    end
    for (int i = 0; i < DATA; i++) send_word($urandom, $urandom_range(0, maxgap), 1'b0);
    check("s_ready_after_data", 32'(bus.s_ready), 0);
  endtask
  task automatic emit(input int n, input int maxgap);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, maxgap)) tick();
      bus.pe_dout_v = 1'b1;
      bus.pe_dout = $urandom;
      exp_res.push_back(bus.pe_dout);
      tick();
      bus.pe_dout_v = 1'b0;
    end
  endtask
  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    repeat (3) tick();
    check("done_pulses", done_cnt - d0, 1);
    check("busy_after_done", 32'(bus.busy), 0);
  endtask
  task automatic drain(input bit rnd);
    int n = 0;
    while (exp_res.size() > 0 && n < 2000) begin
      bus.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.m_valid && bus.m_ready) check("m_data", bus.m_data, exp_res.pop_front());
      tick();
      n++;
    end
    bus.m_ready = 1'b0;
    check("m_valid_after_drain", 32'(bus.m_valid), 0);
    check("results_left", exp_res.size(), 0);
  endtask
  task automatic pop_n(input int k);
    for (int i = 0; i < k; i++) begin
      bus.m_ready = 1'b1;
      check("pop_m_valid", 32'(bus.m_valid), 1);
      if (exp_res.size() > 0) check("pop_m_data", bus.m_data, exp_res.pop_front());
      tick();
    end
    bus.m_ready = 1'b0;
  endtask
  task automatic full_frame(input logic rl, input int gap, input int rgap, input bit rnd);
    bit ld;
    start_frame(rl, ld);
    send_frame_words(ld, gap);
    emit(OUTN, rgap);
    wait_done(300);
    drain(rnd);
  endtask
  initial begin
    vec_t vt[5];
    bit ld;
    int n;
    bus.start = 0; bus.reload = 0; bus.s_valid = 0; bus.s_data = '0;
    bus.pe_dout_v = 0; bus.pe_dout = '0; bus.m_ready = 0;
    repeat (3) tick();
    check("rst_s_ready", 32'(bus.s_ready), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_m_valid", 32'(bus.m_valid), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_err", 32'(bus.err), 0);
    check("rst_pe_din_v", 32'(bus.pe_din_v), 0);
    check("rst_pe_din", bus.pe_din, 0);
    rst = 1'b0;
    tick();
    // frame 1: reload=0 but no coefficients yet, so LOAD is forced
    vt[0] = '{"v_start",   1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
    vt[1] = '{"v_to_load", 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
    vt[2] = '{"v_coef0",   1'b0, 1'b0, 1'b1, 32'h0004_0002, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0004_0002};
    vt[3] = '{"v_coef1",   1'b0, 1'b0, 1'b1, 32'h0003_0001, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0003_0001};
    vt[4] = '{"v_gap",     1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 32'h0003_0001};
    d0 = done_cnt;
    for (int i = 0; i < 5; i++) begin
      bus.start = vt[i].start; bus.reload = vt[i].reload;
      bus.s_valid = vt[i].s_valid; bus.s_data = vt[i].s_data;
      tick();
      check({vt[i].nm, "_s_ready"}, 32'(bus.s_ready), 32'(vt[i].e_s_ready));
      check({vt[i].nm, "_busy"}, 32'(bus.busy), 32'(vt[i].e_busy));
      check({vt[i].nm, "_din_v"}, 32'(bus.pe_din_v), 32'(vt[i].e_din_v));
      check({vt[i].nm, "_load"}, 32'(bus.pe_load), 32'(vt[i].e_load));
      check({vt[i].nm, "_din"}, bus.pe_din, vt[i].e_din);
    end
    bus.start = 1'b0; bus.s_valid = 1'b0;
    for (int i = 2; i < COEF; i++) send_word($urandom, 0, 1'b1);
    coef_m = 1'b1;
    for (int k = 1; k <= DATA; k++) send_word({16'(k), 16'(k)}, 0, 1'b0);
    check("f1_s_ready_after_24", 32'(bus.s_ready), 0);
    check("f1_m_valid_empty", 32'(bus.m_valid), 0);
    emit(1, 0);
    check("f1_m_valid_first", 32'(bus.m_valid), 1);
    check("f1_m_data_first", bus.m_data, exp_res[0]);
    emit(OUTN - 1, 2);
    wait_done(300);
    drain(1'b0);
    // frame 2: coefficients kept, straight to RUN
    full_frame(1'b0, 0, 2, 1'b1);
    for (int f = 0; f < 5; f++) begin
      full_frame(1'($urandom_range(0, 1)), 2, 3, 1'b1);
      check("rand_err", 32'(bus.err), 0);
    end
    // fill FIFO to 32, pop 2 -> 30 held, then a start must wait for 6 pops
    for (int f = 0; f < 4; f++) begin
      start_frame(1'b0, ld);
      send_frame_words(ld, 0);
      emit(OUTN, 0);
      wait_done(300);
    end
    pop_n(2);
    start_frame(1'b0, ld);
    repeat (4) tick();
    check("ws_hold_s_ready", 32'(bus.s_ready), 0);
    check("ws_hold_busy", 32'(bus.busy), 1);
    pop_n(5);
    check("ws_after5_s_ready", 32'(bus.s_ready), 0);
    pop_n(1);
    check("ws_after6_s_ready", 32'(bus.s_ready), 1);
    send_frame_words(ld, 0);
    emit(OUTN, 0);
    wait_done(300);
    drain(1'b0);
    // s_valid pattern 1,0,0,1 in RUN
    start_frame(1'b0, ld);
    n = 0;
    while (!bus.s_ready && n < 20) begin tick(); n++; end
    check("gap_s_ready", 32'(bus.s_ready), 1);
    bus.s_valid = 1'b1; bus.s_data = 32'hA5A5_0001;
    tick();
    check("gap_v0", 32'(bus.pe_din_v), 1);
    check("gap_d0", bus.pe_din, 32'hA5A5_0001);
    check("gap_load0", 32'(bus.pe_load), 0);
    bus.s_valid = 1'b0;
    tick();
    check("gap_v1", 32'(bus.pe_din_v), 0);
    tick();
    check("gap_v2", 32'(bus.pe_din_v), 0);
    check("gap_hold", bus.pe_din, 32'hA5A5_0001);
    bus.s_valid = 1'b1; bus.s_data = 32'hA5A5_0002;
    tick();
    check("gap_v3", 32'(bus.pe_din_v), 1);
    check("gap_d3", bus.pe_din, 32'hA5A5_0002);
    bus.s_valid = 1'b0;
    for (int i = 2; i < DATA - 1; i++) send_word($urandom, $urandom_range(0, 1), 1'b0);
    tick();
    check("gap_23_s_ready", 32'(bus.s_ready), 1);
    send_word($urandom, 0, 1'b0);
    check("gap_24_s_ready", 32'(bus.s_ready), 0);
    emit(OUTN, 1);
    wait_done(300);
    drain(1'b0);
    // stray result in IDLE, then a frame that only gets 5 results
    bus.pe_dout_v = 1'b1; bus.pe_dout = 32'hDEAD_BEEF;
    tick();
    bus.pe_dout_v = 1'b0;
    tick();
    check("stray_err", 32'(bus.err), 1);
    check("stray_m_valid", 32'(bus.m_valid), 0);
    start_frame(1'b0, ld);
    send_frame_words(ld, 0);
    emit(5, 0);
    wait_done(1300);
    check("timeout_err", 32'(bus.err), 3);
    drain(1'b0);
    // reset in the middle of RUN
    start_frame(1'b0, ld);
    for (int i = 0; i < 10; i++) send_word($urandom, 0, 1'b0);
    emit(2, 0);
    check("mid_m_valid", 32'(bus.m_valid), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_s_ready", 32'(bus.s_ready), 0);
    check("mid_rst_m_valid", 32'(bus.m_valid), 0);
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_err", 32'(bus.err), 0);
    exp_res.delete();
    coef_m = 1'b0;
    bus.pe_dout_v = 1'b1;
    tick();
    bus.pe_dout_v = 1'b0;
    tick();
    check("inflight_err", 32'(bus.err), 1);
    full_frame(1'b0, 1, 1, 1'b1);
    check("err_sticky", 32'(bus.err), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
